// File: rtl/ddr4_ctrl_pkg.sv
// DDR4 controller shared definitions: DFI command encodings and refresh scheduler states.
package ddr4_ctrl_pkg;

    // {CS_n, ACT_n, RAS_n, CAS_n, WE_n}
    localparam logic [4:0] CMD_NOP  = 5'b0_1111;
    localparam logic [4:0] CMD_PREA = 5'b0_1010;
    localparam logic [4:0] CMD_REF  = 5'b0_1001;

    localparam int unsigned A10_BIT = 10;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PREA,
        WAIT_RP,
        REF,
        WAIT_RFC
    } sched_state_e;

    function automatic logic is_ref_state(sched_state_e s);
        return (s == PREA) || (s == WAIT_RP) || (s == REF) || (s == WAIT_RFC);
    endfunction

endpackage

// File: rtl/ddr4_ref_timer.sv
// tREFI interval counter with saturating refresh credit and sticky overflow flag.
module ddr4_ref_timer #(
    parameter int unsigned T_REFI       = 1950,
    parameter int unsigned MAX_POSTPONE = 8,
    parameter int unsigned PEND_W       = $clog2(MAX_POSTPONE + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              dec_i,
    output logic [PEND_W-1:0] pending_o,
    output logic              overflow_o
);

    localparam int unsigned CNT_W = $clog2(T_REFI);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(T_REFI - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_POSTPONE);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              tick;

    always_comb begin
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        tick       = 1'b0;
        if (!enable_i) begin
            cnt_d     = '0;
            pending_d = '0;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (tick && (pending_q == PEND_MAX)) begin
                overflow_d = 1'b1;
            end
            // A tick and a REF in the same cycle cancel out
            if (tick && !dec_i) begin
                if (pending_q != PEND_MAX) begin
                    pending_d = pending_q + 1'b1;
                end
            end else if (!tick && dec_i && (pending_q != '0)) begin
                pending_d = pending_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/ddr4_refresh_scheduler.sv
// Shares the DFI phase-0 command slot between the user port and all-bank refresh.
// Optional REF statistics counter enabled by defining DDR4_REF_STATS_EN.
module ddr4_refresh_scheduler
    import ddr4_ctrl_pkg::*;
#(
    parameter int unsigned A_WIDTH      = 17,
    parameter int unsigned BA_WIDTH     = 2,
    parameter int unsigned BG_WIDTH     = 2,
    parameter int unsigned T_REFI       = 1950,
    parameter int unsigned T_RP         = 6,
    parameter int unsigned T_RFC        = 88,
    parameter int unsigned T_CMD2PREA   = 8,
    parameter int unsigned MAX_POSTPONE = 8
) (
    input  logic                                   dfi_clk,
    input  logic                                   reset_n,
    input  logic                                   dfi_init_complete,
    input  logic                                   usr_cmd_valid,
    output logic                                   usr_cmd_ready,
    input  logic [4:0]                             usr_cmd,
    input  logic [A_WIDTH-1:0]                     usr_addr,
    input  logic [BG_WIDTH-1:0]                    usr_bg,
    input  logic [BA_WIDTH-1:0]                    usr_ba,
    output logic [4:0]                             dfi_cmd_p0,
    output logic [A_WIDTH-1:0]                     dfi_address_p0,
    output logic [BG_WIDTH-1:0]                    dfi_bg_p0,
    output logic [BA_WIDTH-1:0]                    dfi_bank_p0,
    output logic                                   ref_busy,
    output logic [$clog2(MAX_POSTPONE+1)-1:0]      ref_pending,
    output logic                                   ref_overflow,
    output logic [15:0]                            ref_issued_cnt
);

    localparam int unsigned PEND_W   = $clog2(MAX_POSTPONE + 1);
    localparam int unsigned GAP_W    = $clog2(T_CMD2PREA + 1);
    localparam int unsigned DLY_MAX  = (T_RFC > T_RP) ? T_RFC : T_RP;
    localparam int unsigned DLY_W    = $clog2(DLY_MAX);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_POSTPONE);

    sched_state_e          state_q, state_d;
    logic [4:0]            cmd_q, cmd_d;
    logic [A_WIDTH-1:0]    addr_q, addr_d;
    logic [BG_WIDTH-1:0]   bg_q, bg_d;
    logic [BA_WIDTH-1:0]   bank_q, bank_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [DLY_W-1:0]      dly_q, dly_d;
    logic [PEND_W-1:0]     pending_w;
    logic                  overflow_w;
    logic                  ref_dec;
    logic                  ready_w;

    ddr4_ref_timer #(
        .T_REFI       (T_REFI),
        .MAX_POSTPONE (MAX_POSTPONE),
        .PEND_W       (PEND_W)
    ) u_ref_timer (
        .clk_i      (dfi_clk),
        .rst_ni     (reset_n),
        .enable_i   (dfi_init_complete),
        .dec_i      (ref_dec),
        .pending_o  (pending_w),
        .overflow_o (overflow_w)
    );

    // Commands are launched on the transition into PREA/REF so the registered
    // output shows the command while the FSM sits in that state. Delay loads
    // are therefore two less than the spacing they produce on the bus.
    always_comb begin
        state_d = state_q;
        cmd_d   = CMD_NOP;
        addr_d  = '0;
        bg_d    = '0;
        bank_d  = '0;
        gap_d   = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        dly_d   = (dly_q != '0) ? dly_q - 1'b1 : dly_q;
        ref_dec = 1'b0;
        ready_w = 1'b0;
        if (!dfi_init_complete) begin
            state_d = IDLE;
            gap_d   = '0;
            dly_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = SERVE;
                SERVE: begin
                    ready_w = (pending_w < PEND_MAX);
                    if (usr_cmd_valid && ready_w) begin
                        cmd_d  = usr_cmd;
                        addr_d = usr_addr;
                        bg_d   = usr_bg;
                        bank_d = usr_ba;
                        gap_d  = GAP_W'(T_CMD2PREA - 1);
                    end else if ((gap_q == '0) && (pending_w != '0) &&
                                 (!usr_cmd_valid || (pending_w == PEND_MAX))) begin
                        state_d         = PREA;
                        cmd_d           = CMD_PREA;
                        addr_d[A10_BIT] = 1'b1;
                    end
                end
                PREA: begin
                    state_d = WAIT_RP;
                    dly_d   = DLY_W'(T_RP - 2);
                end
                WAIT_RP: begin
                    if (dly_q == '0) begin
                        state_d = REF;
                        cmd_d   = CMD_REF;
                    end
                end
                REF: begin
                    ref_dec = 1'b1;
                    state_d = WAIT_RFC;
                    dly_d   = DLY_W'(T_RFC - 2);
                end
                WAIT_RFC: begin
                    if (dly_q == '0) begin
                        // Banks are still closed, so further credits go straight to REF
                        if ((pending_w != '0) && !usr_cmd_valid) begin
                            state_d = REF;
                            cmd_d   = CMD_REF;
                        end else begin
                            state_d = SERVE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge dfi_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            bg_q    <= '0;
            bank_q  <= '0;
            gap_q   <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            bg_q    <= bg_d;
            bank_q  <= bank_d;
            gap_q   <= gap_d;
            dly_q   <= dly_d;
        end
    end

`ifdef DDR4_REF_STATS_EN
    logic [15:0] ref_cnt_q;

    always_ff @(posedge dfi_clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt_q <= '0;
        end else if (ref_dec) begin
            ref_cnt_q <= ref_cnt_q + 16'd1;
        end
    end

    assign ref_issued_cnt = ref_cnt_q;
`else
    assign ref_issued_cnt = '0;
`endif

    assign usr_cmd_ready  = ready_w;
    assign dfi_cmd_p0     = cmd_q;
    assign dfi_address_p0 = addr_q;
    assign dfi_bg_p0      = bg_q;
    assign dfi_bank_p0    = bank_q;
    assign ref_busy       = is_ref_state(state_q);
    assign ref_pending    = pending_w;
    assign ref_overflow   = overflow_w;

endmodule
